// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//  Request/result bundle between the register-file read ports, the
//  multiply/divide unit and the MFHI/MFLO writeback path.
//  master : issues operations and MTHI/MTLO writes, observes status and HI/LO
//  slave  : the multiply/divide unit
//  Signals:
//   op_a, op_b  operands (rs / rt)
//   op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start       operation request
//   hi_we/lo_we direct HI/LO write from op_a
//   busy        operation in flight
//   done        one-cycle pulse, HI/LO just written by an operation
//   div0        qualifies done: divide by zero
//   hi, lo      architectural HI/LO
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_a, op_b, op, start, hi_we, lo_we,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  op_a, op_b, op, start, hi_we, lo_we,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//  Iterative integer multiply/divide unit holding the architectural HI/LO
//  registers. MULT/MULTU use shift-add, DIV/DIVU use restoring
//  shift-subtract, one step per clock over WIDTH steps on operand magnitudes;
//  signs are fixed up in FIN. Every operation takes WIDTH+1 cycles after the
//  accepting edge.
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_div_unit_if.slave (operands, op, start, hi_we/lo_we in;
//          busy, done, div0, hi, lo out)
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting; accepts start, or direct HI/LO writes
//  CALC  | one iteration per clock, cnt counts 0..WIDTH-1
//  FIN   | sign correction, HI/LO written, done pulsed at exit edge
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] qr;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] mcand;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_orig;   // raw dividend, returned in HI on divide by zero
  logic             is_div;
  logic             neg_lo;   // product or quotient needs negation
  logic             neg_hi;   // remainder needs negation (dividend negative)
  logic             div_zero;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, div0_r;

  logic load, step, finish, wr_hi, wr_lo;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    unique case (state)
      IDLE: begin
        // start has priority; a simultaneous HI/LO write is dropped
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          wr_hi = bus.hi_we;
          wr_lo = bus.lo_we;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
      end
      FIN: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- operand conditioning ----------------
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sa    = ~bus.op[0] & bus.op_a[WIDTH-1];
    sb    = ~bus.op[0] & bus.op_b[WIDTH-1];
    mag_a = sa ? -bus.op_a : bus.op_a;
    mag_b = sb ? -bus.op_b : bus.op_b;
  end

  // ---------------- iteration step ----------------
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;
  logic           rem_ge;

  always_comb begin
    mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, mcand} : '0);
    rem_sh  = {acc, qr[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, mcand};
    rem_sub = rem_sh - {1'b0, mcand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      qr       <= '0;
      mcand    <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      acc      <= '0;
      qr       <= mag_a;
      mcand    <= mag_b;
      a_orig   <= bus.op_a;
      is_div   <= bus.op[1];
      neg_lo   <= sa ^ sb;
      neg_hi   <= sa;
      div_zero <= bus.op[1] & (bus.op_b == '0);
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        if (rem_ge) begin
          acc <= rem_sub[WIDTH-1:0];
          qr  <= {qr[WIDTH-2:0], 1'b1};
        end else begin
          acc <= rem_sh[WIDTH-1:0];
          qr  <= {qr[WIDTH-2:0], 1'b0};
        end
      end else begin
        // shift the (WIDTH+1)-bit sum and the multiplier right as one word
        acc <= mul_sum[WIDTH:1];
        qr  <= {mul_sum[0], qr[WIDTH-1:1]};
      end
    end
  end

  // ---------------- result and HI/LO ----------------
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;

  always_comb begin
    prod_mag = {acc, qr};
    prod_fix = neg_lo ? -prod_mag : prod_mag;
    if (div_zero) begin
      hi_res = a_orig;
      lo_res = '1;
    end else if (is_div) begin
      hi_res = neg_hi ? -acc : acc;
      lo_res = neg_lo ? -qr : qr;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      done_r <= finish;
      div0_r <= finish & div_zero;
      if (finish) begin
        hi_r <= hi_res;
        lo_r <= lo_res;
      end else begin
        if (wr_hi) hi_r <= bus.op_a;
        if (wr_lo) lo_r <= bus.op_a;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic clk;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive one accepted request, then scramble operands (they need not be held)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
  endtask

  // bounded wait for done; n = clocks elapsed
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 60);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.op_a = '0; bus.op_b = '0; bus.op = '0;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", bus.done); end
    vecs++; if (bus.div0 !== 1'b0) begin errs++; $display("FAIL reset_div0 got %b want 0", bus.div0); end
    vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    vecs++; if (bus.lo !== 32'h0) begin errs++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multiply;
    vec_t t [6];
    int   n;
    t[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    t[1] = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    t[2] = '{MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    t[3] = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0};
    t[4] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    t[5] = '{MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(t[i].op, t[i].a, t[i].b);
      vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mul%0d_busy got %b want 1", i, bus.busy); end
      wait_done(n);
      vecs++; if (n != 33) begin errs++; $display("FAIL mul%0d_latency got %0d want 33", i, n); end
      vecs++; if (bus.hi !== t[i].hi) begin errs++; $display("FAIL mul%0d_hi got %h want %h", i, bus.hi, t[i].hi); end
      vecs++; if (bus.lo !== t[i].lo) begin errs++; $display("FAIL mul%0d_lo got %h want %h", i, bus.lo, t[i].lo); end
      vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL mul%0d_busy_end got %b want 0", i, bus.busy); end
      tick();
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL mul%0d_done_pulse got %b want 0", i, bus.done); end
    end
  endtask

  task automatic test_divide;
    vec_t t [8];
    int   n;
    t[0] = '{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    t[1] = '{DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    t[2] = '{DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    t[3] = '{DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    t[4] = '{DIVU, 32'd5,        32'd9,        32'h00000005, 32'h00000000, 1'b0};
    t[5] = '{DIVU, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    t[6] = '{DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    t[7] = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(t[i].op, t[i].a, t[i].b);
      wait_done(n);
      vecs++; if (n != 33) begin errs++; $display("FAIL div%0d_latency got %0d want 33", i, n); end
      vecs++; if (bus.hi !== t[i].hi) begin errs++; $display("FAIL div%0d_hi got %h want %h", i, bus.hi, t[i].hi); end
      vecs++; if (bus.lo !== t[i].lo) begin errs++; $display("FAIL div%0d_lo got %h want %h", i, bus.lo, t[i].lo); end
      vecs++; if (bus.div0 !== t[i].dz) begin errs++; $display("FAIL div%0d_div0 got %b want %b", i, bus.div0, t[i].dz); end
      tick();
      vecs++; if (bus.div0 !== 1'b0) begin errs++; $display("FAIL div%0d_div0_pulse got %b want 0", i, bus.div0); end
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    issue(MULTU, 32'd6, 32'd7);
    repeat (4) tick();
    bus.op = DIV; bus.op_a = 32'd100; bus.op_b = 32'd100; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    vecs++; if (n + 5 != 33) begin errs++; $display("FAIL restart_latency got %0d want 33", n + 5); end
    vecs++; if (bus.lo !== 32'h2A) begin errs++; $display("FAIL restart_lo got %h want 0000002a", bus.lo); end
    vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL restart_hi got %h want 00000000", bus.hi); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    issue(DIV, 32'hFFFFFFF9, 32'h2);
    repeat (32) tick();
    bus.op = MULTU; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'h2; bus.start = 1'b1;
    tick();
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL b2b_done got %b want 1", bus.done); end
    vecs++; if (bus.lo !== 32'hFFFFFFFD) begin errs++; $display("FAIL b2b_first_lo got %h want fffffffd", bus.lo); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_fin_reject got busy %b want 0", bus.busy); end
    tick();
    bus.start = 1'b0;
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL b2b_accept got busy %b want 1", bus.busy); end
    wait_done(n);
    vecs++; if (n != 33) begin errs++; $display("FAIL b2b_latency got %0d want 33", n); end
    vecs++; if (bus.hi !== 32'h1) begin errs++; $display("FAIL b2b_hi got %h want 00000001", bus.hi); end
    vecs++; if (bus.lo !== 32'hFFFFFFFE) begin errs++; $display("FAIL b2b_lo got %h want fffffffe", bus.lo); end
    tick();
  endtask

  task automatic test_hilo_write;
    bus.op_a = 32'h1234; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vecs++; if (bus.hi !== 32'h1234) begin errs++; $display("FAIL mthi_lo_hi got %h want 00001234", bus.hi); end
    vecs++; if (bus.lo !== 32'h1234) begin errs++; $display("FAIL mthi_lo_lo got %h want 00001234", bus.lo); end
    bus.op_a = 32'h5678; bus.hi_we = 1'b1;
    tick();
    bus.hi_we = 1'b0;
    vecs++; if (bus.hi !== 32'h5678) begin errs++; $display("FAIL mthi_hi got %h want 00005678", bus.hi); end
    vecs++; if (bus.lo !== 32'h1234) begin errs++; $display("FAIL mthi_lo_kept got %h want 00001234", bus.lo); end
  endtask

  task automatic test_we_ignored;
    int n;
    issue(MULTU, 32'd2, 32'd3);
    bus.op_a = 32'hDEADBEEF; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    vecs++; if (bus.hi !== 32'h5678) begin errs++; $display("FAIL busy_we_hi got %h want 00005678", bus.hi); end
    vecs++; if (bus.lo !== 32'h1234) begin errs++; $display("FAIL busy_we_lo got %h want 00001234", bus.lo); end
    wait_done(n);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vecs++; if (n != 32) begin errs++; $display("FAIL busy_we_latency got %0d want 32", n); end
    vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL busy_we_res_hi got %h want 00000000", bus.hi); end
    vecs++; if (bus.lo !== 32'h6) begin errs++; $display("FAIL busy_we_res_lo got %h want 00000006", bus.lo); end
    tick();
  endtask

  task automatic test_start_and_we;
    int n;
    bus.op = MULTU; bus.op_a = 32'h10000; bus.op_b = 32'h10000;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL start_we_busy got %b want 1", bus.busy); end
    vecs++; if (bus.lo !== 32'h6) begin errs++; $display("FAIL start_we_lo got %h want 00000006", bus.lo); end
    vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL start_we_hi got %h want 00000000", bus.hi); end
    wait_done(n);
    vecs++; if (bus.hi !== 32'h1) begin errs++; $display("FAIL start_we_res_hi got %h want 00000001", bus.hi); end
    vecs++; if (bus.lo !== 32'h0) begin errs++; $display("FAIL start_we_res_lo got %h want 00000000", bus.lo); end
    tick();
  endtask

  task automatic test_reset_mid_op;
    logic seen_done;
    bus.op_a = 32'hAAAA5555; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    issue(DIVU, 32'd9, 32'd2);
    repeat (9) tick();
    #3 rst_n = 1'b0;
    #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL midrst_hi got %h want 00000000", bus.hi); end
    vecs++; if (bus.lo !== 32'h0) begin errs++; $display("FAIL midrst_lo got %h want 00000000", bus.lo); end
    tick(); tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    vecs++; if (seen_done !== 1'b0) begin errs++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
    vecs++; if (bus.lo !== 32'h0) begin errs++; $display("FAIL midrst_lo_after got %h want 00000000", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_start_while_busy();
    test_back_to_back();
    test_hilo_write();
    test_we_ignored();
    test_start_and_we();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
